// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
// Shared definitions for the 8-bit mini-float arithmetic blocks.
//   Format: [7:5] unsigned exponent, [4:0] mantissa, no sign, no hidden bit.
//   value = mantissa * 2^exponent
// Contents:
//   EXP_W, MAN_W  - field widths (fixed at 3 and 5)
//   state_t       - sequencing states of float_sub_seq
//   mini_float_t  - packed {exp, man} view of a mini-float byte
// -----------------------------------------------------------------------------
package float_pkg;

    localparam int EXP_W = 3;
    localparam int MAN_W = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        SUB   = 3'd2,
        NORM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } mini_float_t;

endpackage

// File: rtl/float_sub_seq_shifter.sv
// -----------------------------------------------------------------------------
// float_sub_seq_shifter
// Combinational logical barrel shifter used for operand alignment.
// Ports:
//   data      in  [W-1:0]    value to shift
//   amount    in  [SH_W-1:0] shift distance
//   direction in  1          1 = right shift, 0 = left shift (zero fill)
//   shifted   out [W-1:0]    shifted value; bits shifted out are lost
// -----------------------------------------------------------------------------
module float_sub_seq_shifter #(
    parameter int W    = 5,
    parameter int SH_W = 3
) (
    input  logic [W-1:0]    data,
    input  logic [SH_W-1:0] amount,
    input  logic            direction,
    output logic [W-1:0]    shifted
);

    assign shifted = direction ? (data >> amount) : (data << amount);

endmodule

// File: rtl/float_sub_seq.sv
// -----------------------------------------------------------------------------
// float_sub_seq
// Multi-cycle subtractor for the 8-bit mini-float format. Returns |a - b| as a
// normalized mini-float plus a sign flag. One operation in flight at a time.
// Sequence: IDLE -> ALIGN (1) -> SUB (1) -> NORM (k+1) -> DONE (until taken).
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   a_in       in   [7:0] minuend
//   b_in       in   [7:0] subtrahend
//   in_valid   in   operands valid
//   in_ready   out  high only in IDLE; accept on in_valid && in_ready
//   result     out  [7:0] |a - b|, normalized (8'h00 for a zero difference)
//   neg        out  1 when a - b < 0
//   out_valid  out  high only in DONE
//   out_ready  in   consumer takes the result
// -----------------------------------------------------------------------------
module float_sub_seq
    import float_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] result,
    output logic       neg,
    output logic       out_valid,
    input  logic       out_ready
);

    state_t            state, state_next;

    mini_float_t       op_a, op_b;       // captured operands
    mini_float_t       large_q;          // operand with the larger exponent
    logic [MAN_W-1:0]  small_man_q;      // aligned mantissa of the other one
    logic              swapped_q;        // large_q came from b
    logic [MAN_W-1:0]  mag_q;            // |difference| mantissa, being normalized
    logic [EXP_W-1:0]  e_q;              // exponent of mag_q
    logic              neg_q;

    // ---------------------------------------------------------------- align
    // Equal exponents pick b as the large operand, same ordering as float_add.
    logic              a_larger;
    mini_float_t       large_c, small_c;
    logic [EXP_W-1:0]  exp_diff;
    logic [MAN_W-1:0]  small_man_c;

    assign a_larger = (op_a.exp > op_b.exp);
    assign large_c  = a_larger ? op_a : op_b;
    assign small_c  = a_larger ? op_b : op_a;
    assign exp_diff = large_c.exp - small_c.exp;

    float_sub_seq_shifter #(
        .W    (MAN_W),
        .SH_W (EXP_W)
    ) u_align (
        .data      (small_c.man),
        .amount    (exp_diff),
        .direction (1'b1),
        .shifted   (small_man_c)
    );

    // ----------------------------------------------------------------- sub
    // One extra bit catches the borrow; the magnitude is its two's complement
    // when the aligned small mantissa exceeds the large one.
    logic [MAN_W:0]    raw;
    logic              borrow;
    logic [MAN_W-1:0]  mag_c;

    assign raw    = {1'b0, large_q.man} - {1'b0, small_man_q};
    assign borrow = raw[MAN_W];
    assign mag_c  = borrow ? (MAN_W'(0) - raw[MAN_W-1:0]) : raw[MAN_W-1:0];

    // ---------------------------------------------------------------- norm
    // Shift left until the top mantissa bit is set, the exponent floors at
    // zero, or the magnitude is zero (nothing to normalize).
    logic norm_go;
    assign norm_go = !mag_q[MAN_W-1] && (e_q != '0) && (mag_q != '0);

    // ---------------------------------------------------------- state reg
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // --------------------------------------------------- next state / outputs
    // NOTE: every signal gets a default at the top of the combinational block
    // so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ALIGN;
            end
            ALIGN: state_next = SUB;
            SUB:   state_next = NORM;
            NORM:  if (!norm_go) state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign result = (mag_q == '0) ? 8'h00 : {e_q, mag_q};
    assign neg    = neg_q;

    // ------------------------------------------------------------ datapath
    // NOTE: the datapath registers are reset along with the state so that a
    // mid-operation reset clears result and neg immediately, not just out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a        <= '0;
            op_b        <= '0;
            large_q     <= '0;
            small_man_q <= '0;
            swapped_q   <= 1'b0;
            mag_q       <= '0;
            e_q         <= '0;
            neg_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a <= a_in;
                        op_b <= b_in;
                    end
                end
                ALIGN: begin
                    large_q     <= large_c;
                    small_man_q <= small_man_c;
                    swapped_q   <= !a_larger;
                end
                SUB: begin
                    mag_q <= mag_c;
                    e_q   <= large_q.exp;
                    neg_q <= (mag_c == '0) ? 1'b0 : (swapped_q ^ borrow);
                end
                NORM: begin
                    if (norm_go) begin
                        mag_q <= mag_q << 1;
                        e_q   <= e_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_float_sub_seq
// Directed test-plan cases followed by random operands with random output
// backpressure. Expected values for random operands come from an integer
// model of the subtract rules; latency is counted in clock edges starting
// with the accept edge itself.
// -----------------------------------------------------------------------------
module tb_float_sub_seq;

    logic       clk;
    logic       rst;
    logic [7:0] a_in, b_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] result;
    logic       neg;
    logic       out_valid;
    logic       out_ready;

    int n_chk = 0;
    int n_err = 0;

    float_sub_seq dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .neg       (neg),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Integer model: align by dividing, subtract as signed integers, then
    // normalize by doubling while the value stays below 16 and e is above 0.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic n, output int k);
        int ae, am, be, bm, le, lm, sm, sw, diff, mag, e;
        ae = int'(a[7:5]); am = int'(a[4:0]);
        be = int'(b[7:5]); bm = int'(b[4:0]);
        if (ae > be) begin le = ae; lm = am; sm = bm / (1 << (ae - be)); sw = 0; end
        else         begin le = be; lm = bm; sm = am / (1 << (be - ae)); sw = 1; end
        diff = lm - sm;
        mag  = (diff < 0) ? -diff : diff;
        n    = (mag != 0) && ((sw != 0) != (diff < 0));
        e    = le;
        k    = 0;
        while (mag != 0 && mag < 16 && e > 0) begin
            mag = mag * 2;
            e   = e - 1;
            k++;
        end
        r = (mag == 0) ? 8'h00 : {e[2:0], mag[4:0]};
    endtask

    // Runs one operation. hold = cycles of out_ready=0 while in DONE; poke
    // drives a stray in_valid during that hold, which must be ignored.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_r, input logic exp_n, input int exp_lat,
                          input int hold, input bit poke);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready_idle"}, in_ready, 1);
        out_ready = (hold == 0);
        a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".result"}, result, exp_r);
        check({tag, ".neg"}, neg, exp_n);
        check({tag, ".in_ready_busy"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            if (poke && i == 3) begin
                a_in = 8'hFF; b_in = 8'h01; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_result"}, result, exp_r);
            check({tag, ".hold_neg"}, neg, exp_n);
            check({tag, ".hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".released_valid"}, out_valid, 0);
        check({tag, ".released_in_ready"}, in_ready, 1);
        if (poke) begin
            repeat (6) @(posedge clk);
            #1;
            check({tag, ".stray_ignored"}, out_valid, 0);
            check({tag, ".stray_in_ready"}, in_ready, 1);
        end
    endtask

    initial begin
        logic [7:0] ra, rb, mr;
        logic       mn;
        int         mk;

        rst = 1'b1; a_in = '0; b_in = '0; in_valid = 1'b0; out_ready = 1'b1;
        #12;
        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.result", result, 8'h00);
        check("reset.neg", neg, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op("basic",   8'b011_10000, 8'b001_01000, 8'b010_11100, 1'b0, 5, 0, 0);
        run_op("swapped", 8'b001_01000, 8'b011_10000, 8'b010_11100, 1'b1, 5, 0, 0);
        run_op("borrow",  8'b011_00001, 8'b001_10000, 8'b000_11000, 1'b1, 7, 0, 0);
        run_op("floor",   8'b001_00011, 8'b001_00001, 8'b000_00100, 1'b0, 5, 0, 0);
        run_op("equal",   8'h65,        8'h65,        8'h00,        1'b0, 4, 0, 0);
        run_op("backpr",  8'b011_10000, 8'b001_01000, 8'b010_11100, 1'b0, 5, 10, 1);

        // Reset in the middle of normalization of the borrow case.
        @(negedge clk);
        a_in = 8'b011_00001; b_in = 8'b001_10000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("midrst.neg_before", neg, 1);
        rst = 1'b1;
        #1;
        check("midrst.out_valid", out_valid, 0);
        check("midrst.result", result, 8'h00);
        check("midrst.neg", neg, 0);
        check("midrst.in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 8'b011_00001, 8'b001_10000, 8'b000_11000, 1'b1, 7, 0, 0);

        // Random operands against the model.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            model(ra, rb, mr, mn, mk);
            run_op($sformatf("rand%0d", i), ra, rb, mr, mn, 4 + mk,
                   int'($urandom_range(0, 2)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
